// File: rtl/fft128_frame_loader.sv
// Serial-to-parallel frame loader for the FFT128 datapath: ping-pong buffered
// 128-sample frames with frame-misalignment detection and a saturating error count.
module fft128_frame_loader #(
  parameter int N_PTS = 128,
  parameter int DW    = 34,
  parameter int ECW   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DW-1:0]       s_data,
  input  logic                s_valid,
  input  logic                s_last,
  output logic                s_ready,
  output logic [N_PTS*DW-1:0] frame_data,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic                frame_err,
  output logic [ECW-1:0]      err_cnt
);

  localparam int IW = $clog2(N_PTS);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_PTS - 1);

  logic [DW-1:0] bank [2][N_PTS];
  logic [1:0]    full;
  logic          wr_bank;
  logic          rd_bank;
  logic [IW-1:0] wr_idx;

  logic accept;
  logic consume;
  logic at_last;

  // Both handshakes are gated by rst so nothing is accepted or offered while in reset.
  assign s_ready     = !rst && !full[wr_bank];
  assign frame_valid = !rst && full[rd_bank];
  assign accept      = s_valid && s_ready;
  assign consume     = frame_valid && frame_ready;
  assign at_last     = (wr_idx == LAST_IDX);

  // Sample storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      bank[wr_bank][wr_idx] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= '0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      frame_err <= 1'b0;
      if (accept) begin
        if (s_last && at_last) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wr_idx        <= '0;
        end else if (s_last || at_last) begin
          // Misaligned frame: drop it and restart at index 0 in the same bank.
          wr_idx    <= '0;
          frame_err <= 1'b1;
          if (err_cnt != '1) begin
            err_cnt <= err_cnt + ECW'(1);
          end
        end else begin
          wr_idx <= wr_idx + IW'(1);
        end
      end
      // A completing bank is never the full one being consumed, so both updates coexist.
      if (consume) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

  always_comb begin
    frame_data = '0;
    for (int unsigned k = 0; k < N_PTS; k++) begin
      frame_data[k*DW +: DW] = bank[rd_bank][k];
    end
  end

endmodule
